mano_ctrl_seq: RTL

- Control sequencer for the Mano basic computer datapath.
- Runs a 4-bit sequence counter (SC) and decodes timing T0..T15.
- Latches the opcode decode D0..D7 and the indirect bit I from IR.
- Drives bus-select and LD/INC strobes into the register bank (DATA_REG-style registers for AR, PC, DR, AC, IR) and memory, covering fetch, decode, indirect and the seven memory-reference instructions plus HLT.

---
 rtl/mano_ctrl_pkg.sv | 29 ++
 rtl/mano_seq_counter.sv | 27 ++
 rtl/mano_ctrl_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mano_ctrl_pkg.sv
// Shared encodings for the Mano basic-computer control sequencer.
package mano_ctrl_pkg;

   // Memory-reference opcodes, IR[14:12]; 7 selects register/IO instructions.
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_RRI = 3'd7;

   // Common-bus source select.
   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   // ALU function feeding AC.
   localparam logic [1:0] ALU_NONE = 2'd0;
   localparam logic [1:0] ALU_AND  = 2'd1;
   localparam logic [1:0] ALU_ADD  = 2'd2;
   localparam logic [1:0] ALU_XFER = 2'd3;

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with synchronous reset, increment, clear-to-zero,
// and one-hot timing decode T[sc].
module mano_seq_counter #(
   parameter int SC_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [SC_W-1:0]      sc,
   output logic [(2**SC_W)-1:0] t
);

   // Count register: reset and clear both return to T0; clear wins over inc.
   always_ff @(posedge clk) begin
      if (rst)      sc <= '0;
      else if (clr) sc <= '0;
      else if (inc) sc <= sc + 1'b1;
   end

   // One-hot timing decode.
   always_comb begin
      t     = '0;
      t[sc] = 1'b1;
   end

endmodule

// File: rtl/mano_ctrl_seq.sv
// Mano basic-computer control sequencer: fetch, decode, indirect and the
// memory-reference instruction micro-ops, plus HLT.
module mano_ctrl_seq
   import mano_ctrl_pkg::*;
#(
   parameter int SC_W = 4
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic [15:0]          IR,
   input  logic                 dr_zero,
   output logic [SC_W-1:0]      sc,
   output logic [(2**SC_W)-1:0] t,
   output logic [2:0]           bus_sel,
   output logic                 ar_ld,
   output logic                 ar_inc,
   output logic                 pc_ld,
   output logic                 pc_inc,
   output logic                 dr_ld,
   output logic                 dr_inc,
   output logic                 ir_ld,
   output logic                 ac_ld,
   output logic [1:0]           alu_op,
   output logic                 mem_wr,
   output logic                 halted
);

   localparam int T_W = 2**SC_W;

   logic [2:0]     d_q;
   logic           i_q;
   logic [T_W-1:0] t_raw;
   logic           sc_clr;
   logic           hlt;
   logic           active;

   // Only IR[15:12] and IR[0] steer this block.
   logic unused_ir;
   assign unused_ir = ^IR[11:1];

   assign active = !CLR && !halted;

   mano_seq_counter #(.SC_W(SC_W)) u_sc (
      .clk (CLK),
      .rst (CLR),
      .clr (sc_clr),
      .inc (!halted),
      .sc  (sc),
      .t   (t_raw)
   );

   assign t = halted ? '0 : t_raw;

   // Decode latch at T2 and the halt (inverted S) flip-flop.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         d_q    <= 3'd0;
         i_q    <= 1'b0;
         halted <= 1'b0;
      end else begin
         if (active && t_raw[2]) begin
            d_q <= IR[14:12];
            i_q <= IR[15];
         end
         if (hlt) halted <= 1'b1;
      end
   end

   // Micro-op decode: every strobe comes from (T, D, I) and is quiet in reset/halt.
   always_comb begin
      bus_sel = BUS_NONE;
      ar_ld   = 1'b0;
      ar_inc  = 1'b0;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      dr_ld   = 1'b0;
      dr_inc  = 1'b0;
      ir_ld   = 1'b0;
      ac_ld   = 1'b0;
      alu_op  = ALU_NONE;
      mem_wr  = 1'b0;
      sc_clr  = 1'b0;
      hlt     = 1'b0;
      if (active) begin
         if (t_raw[0]) begin
            bus_sel = BUS_PC;
            ar_ld   = 1'b1;
         end else if (t_raw[1]) begin
            bus_sel = BUS_MEM;
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
         end else if (t_raw[2]) begin
            bus_sel = BUS_IR;
            ar_ld   = 1'b1;
         end else if (t_raw[3]) begin
            if (d_q != OP_RRI) begin
               if (i_q) begin
                  bus_sel = BUS_MEM;
                  ar_ld   = 1'b1;
               end
            end else begin
               // HLT only for a direct RRI with IR[0]; everything else is a NOP.
               hlt    = !i_q && IR[0];
               sc_clr = 1'b1;
            end
         end else if (t_raw[4]) begin
            case (d_q)
               OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                  bus_sel = BUS_MEM;
                  dr_ld   = 1'b1;
               end
               OP_STA: begin
                  bus_sel = BUS_AC;
                  mem_wr  = 1'b1;
                  sc_clr  = 1'b1;
               end
               OP_BUN: begin
                  bus_sel = BUS_AR;
                  pc_ld   = 1'b1;
                  sc_clr  = 1'b1;
               end
               OP_BSA: begin
                  bus_sel = BUS_PC;
                  mem_wr  = 1'b1;
                  ar_inc  = 1'b1;
               end
               default: sc_clr = 1'b1;
            endcase
         end else if (t_raw[5]) begin
            sc_clr = 1'b1;
            case (d_q)
               OP_AND: begin alu_op = ALU_AND;  ac_ld = 1'b1; end
               OP_ADD: begin alu_op = ALU_ADD;  ac_ld = 1'b1; end
               OP_LDA: begin alu_op = ALU_XFER; ac_ld = 1'b1; end
               OP_BSA: begin bus_sel = BUS_AR;  pc_ld = 1'b1; end
               OP_ISZ: begin dr_inc = 1'b1;     sc_clr = 1'b0; end
               default: ;
            endcase
         end else if (t_raw[6]) begin
            sc_clr = 1'b1;
            if (d_q == OP_ISZ) begin
               bus_sel = BUS_DR;
               mem_wr  = 1'b1;
               pc_inc  = dr_zero;
            end
         end else begin
            // T7 and above are never reached in normal flow; fall back to T0.
            sc_clr = 1'b1;
         end
      end
   end

endmodule
